// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous-SRAM port between instruction fetch and data access.
//   clk, rst (async, active-high)
//   inst_sram_* : fetch request in, fetch read data out, stallreq_if when fetch loses
//   data_sram_* : data request in, load data out, stallreq_mem when data loses
//   mem_*       : unified memory port; mem_rdata is valid the cycle after a read
module sram_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_sram_en,
  input  logic [DATA_W/8-1:0] inst_sram_we,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  output logic                stallreq_if,
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_we,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq_mem,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  typedef enum logic [1:0] {RD_NONE, RD_INST, RD_DATA} rd_t;
  rd_t              r_rd_q, w_rd_d;
  logic [CNT_W-1:0] r_starve_cnt, w_starve_d;
  logic [DATA_W-1:0] r_inst_hold, r_data_hold;
  logic             w_gnt_inst, w_gnt_data;
  assign w_gnt_inst = inst_sram_en & (~data_sram_en | r_starve_cnt == CNT_MAX);
  assign w_gnt_data = data_sram_en & ~w_gnt_inst;
  always_comb begin
    w_rd_d     = (w_gnt_inst & ~|inst_sram_we) ? RD_INST :
                 (w_gnt_data & ~|data_sram_we) ? RD_DATA : RD_NONE;
    // fetch losing implies data won, so the saturating count only moves while fetch waits
    w_starve_d = (w_gnt_inst | ~inst_sram_en) ? '0 :
                 (data_sram_en & w_gnt_data & r_starve_cnt != CNT_MAX) ? r_starve_cnt + 1'b1 :
                 r_starve_cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_q       <= RD_NONE;
      r_starve_cnt <= '0;
      r_inst_hold  <= '0;
      r_data_hold  <= '0;
    end else begin
      r_rd_q       <= w_rd_d;
      r_starve_cnt <= w_starve_d;
      if (r_rd_q == RD_INST) r_inst_hold <= mem_rdata;
      if (r_rd_q == RD_DATA) r_data_hold <= mem_rdata;
    end
  end
  assign mem_en          = ~rst & (w_gnt_inst | w_gnt_data);
  assign mem_we          = rst ? '0 : w_gnt_inst ? inst_sram_we : w_gnt_data ? data_sram_we : '0;
  assign mem_addr        = w_gnt_inst ? inst_sram_addr : w_gnt_data ? data_sram_addr : '0;
  assign mem_wdata       = w_gnt_inst ? inst_sram_wdata : w_gnt_data ? data_sram_wdata : '0;
  assign stallreq_if     = ~rst & inst_sram_en & ~w_gnt_inst;
  assign stallreq_mem    = ~rst & data_sram_en & ~w_gnt_data;
  assign inst_sram_rdata = (r_rd_q == RD_INST) ? mem_rdata : r_inst_hold;
  assign data_sram_rdata = (r_rd_q == RD_DATA) ? mem_rdata : r_data_hold;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed table, starvation sequence and randomized model check for sram_port_arbiter.
module tb_sram_port_arbiter;
  localparam int SMAX = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ie = 1'b0, de = 1'b0;
  logic [7:0]  iwe = '0, dwe = '0;
  logic [63:0] ia = '0, iwd = '0, da = '0, dwd = '0, mrd = '0;
  logic [63:0] ird, drd, maddr, mwd;
  logic [7:0]  mwe;
  logic        sif, smem, men;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sram_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(ie), .inst_sram_we(iwe), .inst_sram_addr(ia), .inst_sram_wdata(iwd),
    .inst_sram_rdata(ird), .stallreq_if(sif),
    .data_sram_en(de), .data_sram_we(dwe), .data_sram_addr(da), .data_sram_wdata(dwd),
    .data_sram_rdata(drd), .stallreq_mem(smem),
    .mem_en(men), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwd), .mem_rdata(mrd)
  );
  typedef struct {
    logic rst, ie; logic [63:0] ia; logic de; logic [7:0] dwe; logic [63:0] da, dwd, mrd;
    logic e_en; logic [7:0] e_we; logic [63:0] e_addr, e_wd; logic e_sif, e_smem;
    logic [63:0] e_ird, e_drd;
  } vec_t;
  function automatic vec_t mk(input logic r, i_e, input logic [63:0] i_a, input logic d_e,
                              input logic [7:0] d_we, input logic [63:0] d_a, d_wd, m_rd,
                              input logic x_en, input logic [7:0] x_we, input logic [63:0] x_addr, x_wd,
                              input logic x_sif, x_smem, input logic [63:0] x_ird, x_drd);
    vec_t v;
    v.rst = r; v.ie = i_e; v.ia = i_a; v.de = d_e; v.dwe = d_we; v.da = d_a; v.dwd = d_wd; v.mrd = m_rd;
    v.e_en = x_en; v.e_we = x_we; v.e_addr = x_addr; v.e_wd = x_wd; v.e_sif = x_sif; v.e_smem = x_smem;
    v.e_ird = x_ird; v.e_drd = x_drd;
    return v;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  // behavioural reference: who owns the returning read, what each requester last received, fetch wait length
  int          m_owner = 0;
  int          m_wait = 0;
  logic [63:0] m_ih = '0, m_dh = '0;
  logic        g_i, g_d;
  task automatic model_grant();
    g_i = ie && (!de || m_wait >= SMAX);
    g_d = de && !g_i;
  endtask
  task automatic model_edge();
    model_grant();
    if (rst) begin
      m_owner = 0; m_wait = 0; m_ih = '0; m_dh = '0;
    end else begin
      if (m_owner == 1) m_ih = mrd;
      if (m_owner == 2) m_dh = mrd;
      m_owner = (g_i && iwe == 0) ? 1 : (g_d && dwe == 0) ? 2 : 0;
      if (g_i || !ie) m_wait = 0;
      else if (g_d) m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
    end
  endtask
  task automatic model_check();
    if (rst) begin
      m_owner = 0; m_wait = 0; m_ih = '0; m_dh = '0;
    end
    model_grant();
    chk("rnd_mem_en", 64'(men), 64'(!rst && (g_i || g_d)));
    chk("rnd_mem_we", 64'(mwe), rst ? 64'd0 : g_i ? 64'(iwe) : g_d ? 64'(dwe) : 64'd0);
    if (!rst) begin
      chk("rnd_mem_addr", maddr, g_i ? ia : g_d ? da : 64'd0);
      chk("rnd_mem_wdata", mwd, g_i ? iwd : g_d ? dwd : 64'd0);
    end
    chk("rnd_stall_if", 64'(sif), 64'(!rst && ie && !g_i));
    chk("rnd_stall_mem", 64'(smem), 64'(!rst && de && !g_d));
    chk("rnd_inst_rdata", ird, m_owner == 1 ? mrd : m_ih);
    chk("rnd_data_rdata", drd, m_owner == 2 ? mrd : m_dh);
  endtask
  vec_t tbl[13];
  initial begin
    //            rst ie ia       de dwe    da       dwd   mrd      en we     addr     wd    sif smem ird      drd
    tbl[0]  = mk(1, 1, 64'h1000, 1, 8'h00, 64'h2000, 0,    64'h0,    0, 8'h00, 64'h2000, 0,    0, 0, 64'h0,    64'h0);
    tbl[1]  = mk(0, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'h77,   0, 8'h00, 64'h0,    0,    0, 0, 64'h0,    64'h0);
    tbl[2]  = mk(0, 1, 64'h1000, 0, 8'h00, 64'h0,    0,    64'h0,    1, 8'h00, 64'h1000, 0,    0, 0, 64'h0,    64'h0);
    tbl[3]  = mk(0, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'hDEAD, 0, 8'h00, 64'h0,    0,    0, 0, 64'hDEAD, 64'h0);
    tbl[4]  = mk(0, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'hBEEF, 0, 8'h00, 64'h0,    0,    0, 0, 64'hDEAD, 64'h0);
    tbl[5]  = mk(0, 1, 64'h1000, 1, 8'h00, 64'h2000, 0,    64'h1,    1, 8'h00, 64'h2000, 0,    1, 0, 64'hDEAD, 64'h0);
    tbl[6]  = mk(0, 1, 64'h1000, 0, 8'h00, 64'h0,    0,    64'h1234, 1, 8'h00, 64'h1000, 0,    0, 0, 64'hDEAD, 64'h1234);
    tbl[7]  = mk(0, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'h9999, 0, 8'h00, 64'h0,    0,    0, 0, 64'h9999, 64'h1234);
    tbl[8]  = mk(0, 0, 64'h0,    1, 8'hFF, 64'h3000, 64'h55, 64'hAAAA, 1, 8'hFF, 64'h3000, 64'h55, 0, 0, 64'h9999, 64'h1234);
    tbl[9]  = mk(0, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'hBBBB, 0, 8'h00, 64'h0,    0,    0, 0, 64'h9999, 64'h1234);
    tbl[10] = mk(0, 0, 64'h0,    1, 8'h00, 64'h4000, 0,    64'h0,    1, 8'h00, 64'h4000, 0,    0, 0, 64'h9999, 64'h1234);
    tbl[11] = mk(1, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'hCCCC, 0, 8'h00, 64'h0,    0,    0, 0, 64'h0,    64'h0);
    tbl[12] = mk(0, 0, 64'h0,    0, 8'h00, 64'h0,    0,    64'hDDDD, 0, 8'h00, 64'h0,    0,    0, 0, 64'h0,    64'h0);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      rst = tbl[k].rst; ie = tbl[k].ie; ia = tbl[k].ia; iwe = '0; iwd = '0;
      de = tbl[k].de; dwe = tbl[k].dwe; da = tbl[k].da; dwd = tbl[k].dwd; mrd = tbl[k].mrd;
      #4;
      chk($sformatf("v%0d_mem_en", k), 64'(men), 64'(tbl[k].e_en));
      chk($sformatf("v%0d_mem_we", k), 64'(mwe), 64'(tbl[k].e_we));
      if (!tbl[k].rst) begin
        chk($sformatf("v%0d_mem_addr", k), maddr, tbl[k].e_addr);
        chk($sformatf("v%0d_mem_wdata", k), mwd, tbl[k].e_wd);
      end
      chk($sformatf("v%0d_stall_if", k), 64'(sif), 64'(tbl[k].e_sif));
      chk($sformatf("v%0d_stall_mem", k), 64'(smem), 64'(tbl[k].e_smem));
      chk($sformatf("v%0d_inst_rdata", k), ird, tbl[k].e_ird);
      chk($sformatf("v%0d_data_rdata", k), drd, tbl[k].e_drd);
    end
    // continuous contention: data wins SMAX cycles, fetch once, then data again
    for (int c = 0; c <= SMAX + 1; c++) begin
      @(posedge clk); #1;
      ie = 1; ia = 64'h1000; de = 1; da = 64'h2000; dwe = '0; mrd = 64'(c);
      #4;
      chk($sformatf("starve%0d_addr", c), maddr, (c == SMAX) ? 64'h1000 : 64'h2000);
      chk($sformatf("starve%0d_stall_if", c), 64'(sif), 64'(c != SMAX));
      chk($sformatf("starve%0d_stall_mem", c), 64'(smem), 64'(c == SMAX));
    end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      rst = (c == 0) || ($urandom_range(0, 39) == 0);
      ie  = $urandom_range(0, 2) != 0;
      de  = $urandom_range(0, 2) != 0;
      iwe = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      dwe = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
      ia  = {$urandom, $urandom}; da = {$urandom, $urandom};
      iwd = {$urandom, $urandom}; dwd = {$urandom, $urandom};
      mrd = {$urandom, $urandom};
      #4;
      model_check();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
